// File: rtl/mc_port_arbiter.sv
// Round-robin sharing of one memory-controller port among NUM_REQ requesters.
// Loads record their requester id in a tag FIFO so in-order read responses route back.
module mc_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int TAG_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_ld,
  input  logic [NUM_REQ-1:0]    req_st,
  input  logic [NUM_REQ*48-1:0] req_vadr,
  input  logic [NUM_REQ*64-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_gnt,
  output logic [NUM_REQ-1:0]    rsp_push,
  output logic [63:0]           rsp_data,
  input  logic [NUM_REQ-1:0]    rsp_stall,
  output logic                  mc_req_ld,
  output logic                  mc_req_st,
  output logic [47:0]           mc_req_vadr,
  output logic [63:0]           mc_req_data,
  input  logic                  mc_rd_rq_stall,
  input  logic                  mc_wr_rq_stall,
  input  logic                  mc_rsp_push,
  input  logic [63:0]           mc_rsp_data,
  output logic                  mc_rsp_stall,
  output logic                  idle,
  output logic                  err_unexp
);

  localparam int TP_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W = TP_W + 1;

  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] ld_elig, st_elig, elig;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_is_ld;

  logic               mc_req_ld_reg, mc_req_st_reg;
  logic [47:0]        mc_req_vadr_reg;
  logic [63:0]        mc_req_data_reg;

  logic [ID_W-1:0]    tag_mem [TAG_DEPTH];
  logic [TP_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   tag_count_reg;
  logic               fifo_empty, fifo_full, tag_push, tag_pop, can_push;

  logic               rsp_valid_reg;
  logic [ID_W-1:0]    rsp_id_reg;
  logic [63:0]        rsp_data_reg;
  logic               mc_rsp_stall_reg;
  logic               err_unexp_reg;

  assign fifo_empty = (tag_count_reg == '0);
  assign fifo_full  = (tag_count_reg == CNT_W'(TAG_DEPTH));
  assign tag_pop    = mc_rsp_push & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept a load.
  assign can_push   = ~fifo_full | tag_pop;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign ld_elig[gi] = req_ld[gi] & ~mc_rd_rq_stall & can_push;
      assign st_elig[gi] = req_st[gi] & ~req_ld[gi] & ~mc_wr_rq_stall;
      assign elig[gi]    = ld_elig[gi] | st_elig[gi];
    end
  endgenerate

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && elig[(int'(ptr_reg) + k) % NUM_REQ]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'((int'(ptr_reg) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_gnt   = '0;
    gnt_is_ld = 1'b0;
    ptr_next  = ptr_reg;
    if (gnt_any) begin
      req_gnt[gnt_id] = 1'b1;
      gnt_is_ld       = req_ld[gnt_id];
      ptr_next        = ID_W'((int'(gnt_id) + 1) % NUM_REQ);
    end
  end

  assign tag_push = gnt_any & gnt_is_ld;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg         <= '0;
      mc_req_ld_reg   <= 1'b0;
      mc_req_st_reg   <= 1'b0;
      mc_req_vadr_reg <= '0;
      mc_req_data_reg <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      mc_req_ld_reg <= gnt_any & gnt_is_ld;
      mc_req_st_reg <= gnt_any & ~gnt_is_ld;
      if (gnt_any) begin
        mc_req_vadr_reg <= req_vadr[48*gnt_id +: 48];
        mc_req_data_reg <= req_data[64*gnt_id +: 64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      tag_count_reg <= '0;
    end else begin
      if (tag_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (tag_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      tag_count_reg <= tag_count_reg + CNT_W'(tag_push) - CNT_W'(tag_pop);
    end
  end

  // Tag storage has no reset so it maps onto RAM; validity lives in tag_count_reg.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr_reg] <= gnt_id;
    if (tag_pop)  rsp_id_reg <= tag_mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg    <= 1'b0;
      rsp_data_reg     <= '0;
      mc_rsp_stall_reg <= 1'b0;
      err_unexp_reg    <= 1'b0;
    end else begin
      rsp_valid_reg    <= tag_pop;
      mc_rsp_stall_reg <= |rsp_stall;
      if (tag_pop) rsp_data_reg <= mc_rsp_data;
      if (mc_rsp_push && fifo_empty) err_unexp_reg <= 1'b1;
    end
  end

  always_comb begin
    rsp_push = '0;
    if (rsp_valid_reg) rsp_push[rsp_id_reg] = 1'b1;
  end

  assign rsp_data     = rsp_data_reg;
  assign mc_req_ld    = mc_req_ld_reg;
  assign mc_req_st    = mc_req_st_reg;
  assign mc_req_vadr  = mc_req_vadr_reg;
  assign mc_req_data  = mc_req_data_reg;
  assign mc_rsp_stall = mc_rsp_stall_reg;
  assign err_unexp    = err_unexp_reg;
  assign idle = ~(|req_ld) & ~(|req_st) & fifo_empty & ~mc_req_ld_reg & ~mc_req_st_reg;

endmodule

// File: doc/mc_port_arbiter.md
Name: mc_port_arbiter

Overview:
- Shares one memory-controller (MC) port among NUM_REQ requesters: read-fetch, hash lookup, candidate fetch and result-store engines.
- Each requester sees a private ld/st request interface and a private response interface.
- Round-robin arbitration; respects MC read and write request stalls.
- MC read responses return in request order. A load-tag FIFO routes each response to the requester that issued the load.
- Sits between the shepard engines and one MC channel, so fewer physical MC ports are needed.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester-id width; equals clog2(NUM_REQ)
TAG_DEPTH, 32, load-tag FIFO depth; equals the maximum outstanding loads (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_ld  in  NUM_REQ  per-requester load request
req_st  in  NUM_REQ  per-requester store request; ld and st both high = ld only
req_vadr  in  NUM_REQ*48  per-requester virtual address; slice i = [48*i+47:48*i]
req_data  in  NUM_REQ*64  per-requester store data
req_gnt  out  NUM_REQ  combinational accept; request consumed when req and gnt both high
rsp_push  out  NUM_REQ  per-requester response valid
rsp_data  out  64  response data, shared by all requesters
rsp_stall  in  NUM_REQ  requester response almost-full
mc_req_ld  out  1  MC load request
mc_req_st  out  1  MC store request
mc_req_vadr  out  48  MC address
mc_req_data  out  64  MC store data
mc_rd_rq_stall  in  1  MC cannot accept loads
mc_wr_rq_stall  in  1  MC cannot accept stores
mc_rsp_push  in  1  MC read response valid
mc_rsp_data  in  64  MC read response data
mc_rsp_stall  out  1  back-pressure to MC responses
idle  out  1  no pending requests and no outstanding loads
err_unexp  out  1  sticky: response arrived with no outstanding load

Behaviour:
- Reset values: all outputs 0 except idle=1. Reset empties the tag FIFO, clears the outstanding count and err_unexp, and sets the RR pointer to 0.
- Reset mid-operation drops in-flight tags. Responses that arrive after reset set err_unexp.
- Eligibility, per requester i:
  - Load: req_ld[i] high, mc_rd_rq_stall low, and tag FIFO not full.
  - Store: req_st[i] high, req_ld[i] low, and mc_wr_rq_stall low.
- Arbitration:
  - Pick the first eligible requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - At most one grant per cycle. After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
  - The pointer holds when nothing is granted.
  - An ineligible requester is skipped; it does not block the others.
- Issue pipeline:
  - The granted request is registered onto mc_req_* in the next cycle (1-cycle latency).
  - mc_req_ld and mc_req_st are each high for exactly one cycle per grant and are never both high.
  - mc_req_vadr and mc_req_data hold their last value when idle.
- Tag FIFO: a granted load pushes its requester id in the grant cycle.
  - full = count == TAG_DEPTH.
  - A push and a pop in the same cycle are allowed when full; the count is unchanged.
- Response routing:
  - When mc_rsp_push is high, pop the FIFO head id.
  - Next cycle: rsp_push[id]=1 and rsp_data=mc_rsp_data (1-cycle latency).
  - mc_rsp_push with the FIFO empty: no pop, no rsp_push, err_unexp=1 until reset.
- Back-pressure:
  - mc_rsp_stall is registered OR of rsp_stall (1-cycle delay).
  - Responses that arrive while stalled are still delivered, so requesters must tolerate at least 3 extra pushes after asserting rsp_stall.
  - rsp_stall does not gate new loads.
- idle = no req_ld/req_st high, tag count 0, and no issue register valid.

Test Plan:
1. Requester 1 load, vadr 0x17520 (0x2EA4<<3), then mc_rsp_data=0x00003000000036F0 -> cycle+1: mc_req_ld=1, vadr=0x17520. Response: rsp_push=4'b0010 one cycle after mc_rsp_push, with matching data.
2. All 4 requesters load in the same cycle after reset -> grants 0,1,2,3 on consecutive cycles. Four responses D0..D3 -> rsp_push one-hot 0,1,2,3 carrying D0..D3.
3. mc_rd_rq_stall=1 with req_ld[0] and req_st[3] (vadr 0x20, data 0x5A) -> only 3 granted; mc_req_st=1, vadr 0x20, data 0x5A; mc_req_ld=0 until the stall drops.
4. TAG_DEPTH=4: 5 loads from requester 2 with no responses -> 4 granted, 5th held. One mc_rsp_push -> 5th granted in the same cycle as the pop.
5. mc_rsp_push with nothing outstanding -> err_unexp=1 and stays high; rsp_push stays 0. rst -> err_unexp=0 and idle=1.
6. rsp_stall[2]=1 -> mc_rsp_stall=1 one cycle later. Two responses pushed during the stall are still delivered to their requesters.
